// File: rtl/slave_port_param.sv
// Serial command slave: shifts in address/write data LSB first, strobes a memory port, and shifts read data out.
// Optional SLAVE_PORT_PARITY_EN adds an even parity bit after each data word in both directions.
module slave_port_param #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic                  rx_burst,
    input  logic                  master_valid,
    input  logic                  master_ready,
    input  logic                  rx_address,
    input  logic                  rx_data,
    output logic                  slave_ready,
    output logic                  slave_valid,
    output logic                  tx_data,
    output logic                  rx_done,
    output logic                  slave_tx_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  parity_err
);
`ifdef SLAVE_PORT_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int WBITS   = DATA_WIDTH + PAR_BITS;
    localparam int CNT_MAX = (ADDR_WIDTH > WBITS) ? ADDR_WIDTH : WBITS;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int BW      = $clog2(BURST_LEN);

    // state  | meaning
    // IDLE   | wait for a command with exactly one enable
    // ADDR   | shift in address bits 1..ADDR_WIDTH-1
    // WDATA  | shift in one write beat (plus parity when enabled)
    // MWRITE | single-cycle memory write strobe
    // MREAD  | single-cycle memory read strobe
    // MWAIT  | wait for mem_rvalid
    // TX     | shift read beat out under master_ready
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, MWRITE, MREAD, MWAIT, TX} state_t;

    state_t                state, next_state;
    logic                  op_read, burst_q;
    logic [CW-1:0]         bit_cnt;
    logic [BW-1:0]         beat_cnt;
    logic [ADDR_WIDTH-1:0] addr_sr;
    logic [DATA_WIDTH-1:0] data_sr;
    logic [WBITS-1:0]      tx_sr, rdata_word;
    logic                  cmd_ok, cnt_zero, beats_left, par_slot, par_fail;
    logic                  mem_write_d, mem_read_d, slave_valid_d, tx_done_d;

    assign cmd_ok     = master_valid && (read_en ^ write_en);
    assign cnt_zero   = (bit_cnt == '0);
    assign beats_left = burst_q && (beat_cnt != '0);

`ifdef SLAVE_PORT_PARITY_EN
    assign par_slot   = cnt_zero;
    assign rdata_word = {^mem_rdata, mem_rdata};
`else
    assign par_slot   = 1'b0;
    assign rdata_word = mem_rdata;
`endif
    assign par_fail = par_slot && (state == WDATA) && master_valid && (rx_data != ^data_sr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_ok) next_state = ADDR;
            ADDR:    if (master_valid && cnt_zero) next_state = op_read ? MREAD : WDATA;
            WDATA:   if (master_valid && cnt_zero) next_state = par_fail ? IDLE : MWRITE;
            MWRITE:  next_state = beats_left ? WDATA : IDLE;
            MREAD:   next_state = MWAIT;
            MWAIT:   if (mem_rvalid) next_state = TX;
            TX:      if (master_ready && cnt_zero) next_state = beats_left ? MREAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are computed from the upcoming state so their registers line up with it.
    always_comb begin
        mem_write_d   = (next_state == MWRITE);
        mem_read_d    = (next_state == MREAD);
        slave_valid_d = (next_state == TX);
        tx_done_d     = (state == TX) && (next_state != TX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_write     <= 1'b0;
            rx_done       <= 1'b0;
            mem_read      <= 1'b0;
            slave_valid   <= 1'b0;
            slave_tx_done <= 1'b0;
            parity_err    <= 1'b0;
        end else begin
            mem_write     <= mem_write_d;
            rx_done       <= mem_write_d;
            mem_read      <= mem_read_d;
            slave_valid   <= slave_valid_d;
            slave_tx_done <= tx_done_d;
            parity_err    <= par_fail;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_read  <= 1'b0;
            burst_q  <= 1'b0;
            bit_cnt  <= '0;
            beat_cnt <= '0;
            addr_sr  <= '0;
            data_sr  <= '0;
            tx_sr    <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_ok) begin
                    op_read  <= read_en;
                    burst_q  <= rx_burst;
                    beat_cnt <= BW'(BURST_LEN - 1);
                    addr_sr  <= {rx_address, addr_sr[ADDR_WIDTH-1:1]};
                    bit_cnt  <= CW'(ADDR_WIDTH - 2);
                end
                ADDR: if (master_valid) begin
                    addr_sr <= {rx_address, addr_sr[ADDR_WIDTH-1:1]};
                    bit_cnt <= cnt_zero ? CW'(WBITS - 1) : bit_cnt - 1'b1;
                end
                WDATA: if (master_valid) begin
                    if (!par_slot) data_sr <= {rx_data, data_sr[DATA_WIDTH-1:1]};
                    if (!cnt_zero) bit_cnt <= bit_cnt - 1'b1;
                end
                MWRITE: if (beats_left) begin
                    addr_sr  <= addr_sr + 1'b1;
                    beat_cnt <= beat_cnt - 1'b1;
                    bit_cnt  <= CW'(WBITS - 1);
                end
                MWAIT: if (mem_rvalid) begin
                    tx_sr   <= rdata_word;
                    bit_cnt <= CW'(WBITS - 1);
                end
                TX: if (master_ready) begin
                    tx_sr <= tx_sr >> 1;
                    if (!cnt_zero) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (beats_left) begin
                        addr_sr  <= addr_sr + 1'b1;
                        beat_cnt <= beat_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign slave_ready = (state == IDLE) || (state == ADDR) || (state == WDATA);
    assign mem_addr    = addr_sr;
    assign mem_wdata   = data_sr;
    assign tx_data     = tx_sr[0];

endmodule

// File: tb/tb_slave_port_param.sv
// Bench for slave_port_param: directed scenarios plus randomized reads/writes against a memory-array reference model.
module tb_slave_port_param;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int BL = 4;
`ifdef SLAVE_PORT_PARITY_EN
    localparam int WB = DW + 1;
`else
    localparam int WB = DW;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          read_en = 1'b0, write_en = 1'b0, rx_burst = 1'b0;
    logic          master_valid = 1'b0, master_ready = 1'b0;
    logic          rx_address = 1'b0, rx_data = 1'b0;
    logic          slave_ready, slave_valid, tx_data, rx_done, slave_tx_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write, mem_read;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rvalid = 1'b0;
    logic          parity_err;

    slave_port_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset),
        .read_en(read_en), .write_en(write_en), .rx_burst(rx_burst),
        .master_valid(master_valid), .master_ready(master_ready),
        .rx_address(rx_address), .rx_data(rx_data),
        .slave_ready(slave_ready), .slave_valid(slave_valid), .tx_data(tx_data),
        .rx_done(rx_done), .slave_tx_done(slave_tx_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] beat_data [BL];
    int n_assert = 0, n_fail = 0;
    int n_wr = 0, n_rd = 0, n_perr = 0, n_rxd_bad = 0;
    int exp_wr = 0, exp_rd = 0, exp_perr = 0;
    int rd_lat = 3, rd_cnt = 0;
    bit noise_en = 1'b0;
    logic [AW-1:0] resp_addr = '0;

    // Strobe monitor
    always @(negedge clk) begin
        if (mem_write) n_wr++;
        if (mem_read) n_rd++;
        if (parity_err) n_perr++;
        if (rx_done !== mem_write) n_rxd_bad++;
    end

    // Memory responder: answers rd_lat cycles after the mem_read cycle; random noise otherwise
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt = 0;
            mem_rvalid = 1'b0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata = DW'($urandom);
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = mem[resp_addr];
                end
            end else if (!mem_read && noise_en) begin
                mem_rvalid = ($urandom_range(3) == 0);
            end
            if (mem_read) begin
                rd_cnt = rd_lat;
                resp_addr = mem_addr;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WB-1:0] exp_word(input logic [DW-1:0] d);
`ifdef SLAVE_PORT_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    task automatic idle_cycle();
        master_valid = 1'b0;
        rx_address = 1'($urandom);
        rx_data = 1'($urandom);
        tick();
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input bit is_addr,
                             input int stall_pct, input int stall_at, input int stall_len);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) for (int s = 0; s < stall_len; s++) idle_cycle();
            while (int'($urandom_range(99)) < stall_pct) idle_cycle();
            master_valid = 1'b1;
            if (is_addr) rx_address = v[i];
            else rx_data = v[i];
            tick();
        end
        master_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic rd, input logic wr, input logic burst, input logic [AW-1:0] addr,
                            input int stall_pct, input int stall_at, input int stall_len);
        read_en = rd;
        write_en = wr;
        rx_burst = burst;
        master_valid = 1'b1;
        rx_address = addr[0];
        tick();
        read_en = 1'b0;
        write_en = 1'b0;
        rx_burst = 1'($urandom);
        send_bits(32'(addr >> 1), AW - 1, 1'b1, stall_pct, stall_at, stall_len);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic burst, input int stall_pct,
                            input int stall_at, input int stall_len);
        int nb;
        logic [AW-1:0] a;
        nb = burst ? BL : 1;
        a = addr;
        send_cmd(1'b0, 1'b1, burst, addr, stall_pct, stall_at, stall_len);
        for (int b = 0; b < nb; b++) begin
            send_bits(32'(exp_word(beat_data[b])), WB, 1'b0, stall_pct, -1, 0);
            check("wr_strobe", 32'(mem_write), 32'd1);
            check("wr_rx_done", 32'(rx_done), 32'd1);
            check("wr_addr", 32'(mem_addr), 32'(a));
            check("wr_data", 32'(mem_wdata), 32'(beat_data[b]));
            mem[a] = beat_data[b];
            exp_wr++;
            tick();
            check("wr_single_cycle", 32'(mem_write), 32'd0);
            a = a + 1'b1;
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic burst, input int stall_pct,
                           input int rdy_mode, input int lat);
        int nb, k, budget;
        logic [AW-1:0] a;
        logic [WB-1:0] got;
        logic tog;
        nb = burst ? BL : 1;
        a = addr;
        rd_lat = lat;
        send_cmd(1'b1, 1'b0, burst, addr, stall_pct, -1, 0);
        for (int b = 0; b < nb; b++) begin
            check("rd_strobe", 32'(mem_read), 32'd1);
            check("rd_addr", 32'(mem_addr), 32'(a));
            exp_rd++;
            k = 0;
            budget = 0;
            got = '0;
            tog = 1'b1;
            while (k < WB && budget < 300) begin
                master_ready = (rdy_mode == 0) ? tog : 1'($urandom);
                tog = ~tog;
                if (slave_valid && master_ready) begin
                    got[k] = tx_data;
                    k++;
                end
                tick();
                budget++;
            end
            master_ready = 1'b0;
            check("rd_bits_accepted", 32'(k), 32'(WB));
            check("rd_tx_bits", 32'(got), 32'(exp_word(mem[a])));
            check("rd_tx_done", 32'(slave_tx_done), 32'd1);
            a = a + 1'b1;
        end
    endtask

    initial begin
        int start_cyc, k, budget, n0w, n0r;
        logic [AW-1:0] last_wr, ad;
        logic op, br;

        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        last_wr = '0;

        // Reset values
        repeat (3) tick();
        check("rst_slave_ready", 32'(slave_ready), 32'd1);
        check("rst_slave_valid", 32'(slave_valid), 32'd0);
        check("rst_strobes", 32'({mem_write, mem_read, rx_done, slave_tx_done, parity_err, tx_data}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        #2 reset = 1'b1;
        tick();

        // Write 0xC6 to 0x5A3 with continuous valid: strobe exactly after 20 bits
        beat_data[0] = 8'hC6;
        start_cyc = 0;
        read_en = 1'b0; write_en = 1'b1; rx_burst = 1'b0; master_valid = 1'b1;
        rx_address = 1'b1;
        tick(); start_cyc++;
        write_en = 1'b0;
        for (int i = 1; i < AW; i++) begin
            rx_address = ((12'h5A3 >> i) & 12'h1) != 0;
            tick(); start_cyc++;
        end
        for (int i = 0; i < WB; i++) begin
            check("lat_no_early_write", 32'(mem_write), 32'd0);
            rx_data = exp_word(8'hC6)[i];
            tick(); start_cyc++;
        end
        master_valid = 1'b0;
        check("lat_bits", 32'(start_cyc), 32'(AW + WB));
        check("lat_mem_write", 32'(mem_write), 32'd1);
        check("lat_rx_done", 32'(rx_done), 32'd1);
        check("lat_addr", 32'(mem_addr), 32'h5A3);
        check("lat_data", 32'(mem_wdata), 32'hC6);
        mem[12'h5A3] = 8'hC6;
        exp_wr++;
        tick();
        check("lat_write_single", 32'(mem_write), 32'd0);

        // Read 0x010 holding 0x3C, 3-cycle memory latency, master_ready toggling
        mem[12'h010] = 8'h3C;
        do_read(12'h010, 1'b0, 0, 0, 3);

        // Burst write across the address wrap, then read it back as a burst
        beat_data[0] = 8'h11; beat_data[1] = 8'h22; beat_data[2] = 8'h33; beat_data[3] = 8'h44;
        do_write(12'hFFE, 1'b1, 0, -1, 0);
        check("burst_idle", 32'(slave_ready), 32'd1);
        check("burst_wrap_mem", 32'({mem[12'h000], mem[12'h001]}), 32'h3344);
        do_read(12'hFFE, 1'b1, 0, 1, 2);

        // Dual and no enable ignored in IDLE
        n0w = n_wr; n0r = n_rd;
        read_en = 1'b1; write_en = 1'b1; master_valid = 1'b1;
        repeat (3) begin rx_address = 1'($urandom); tick(); end
        read_en = 1'b0; write_en = 1'b0;
        repeat (2) begin rx_address = 1'($urandom); tick(); end
        master_valid = 1'b0;
        repeat (4) tick();
        check("dual_en_no_write", 32'(n_wr), 32'(n0w));
        check("dual_en_no_read", 32'(n_rd), 32'(n0r));

        // Three-cycle stall mid-address must not disturb the address
        beat_data[0] = 8'hA5;
        do_write(12'h6B9, 1'b0, 0, 5, 3);
        do_read(12'h6B9, 1'b0, 0, 0, 1);

        // Reset while bit 3 of a read beat is on the wire
        rd_lat = 2;
        send_cmd(1'b1, 1'b0, 1'b0, 12'h234, 0, -1, 0);
        exp_rd++;
        k = 0; budget = 0;
        while (k < 3 && budget < 100) begin
            master_ready = 1'b1;
            if (slave_valid) k++;
            tick();
            budget++;
        end
        check("rst_mid_tx_reached", 32'({k[7:0], 7'd0, slave_valid}), 32'h0301);
        master_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_async_valid", 32'(slave_valid), 32'd0);
        check("rst_async_ready", 32'(slave_ready), 32'd1);
        check("rst_async_tx_data", 32'(tx_data), 32'd0);
        n0r = n_rd;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("rst_no_more_reads", 32'(n_rd), 32'(n0r));
        beat_data[0] = 8'h7F;
        do_write(12'h001, 1'b0, 0, -1, 0);

`ifdef SLAVE_PORT_PARITY_EN
        // Bad parity bit: word dropped with a parity_err pulse; good parity bit: normal write
        send_cmd(1'b0, 1'b1, 1'b0, 12'h0A0, 0, -1, 0);
        send_bits({23'd0, 1'b1, 8'hC6}, DW + 1, 1'b0, 0, -1, 0);
        check("par_no_write", 32'(mem_write), 32'd0);
        check("par_no_rx_done", 32'(rx_done), 32'd0);
        check("par_err_set", 32'(parity_err), 32'd1);
        exp_perr++;
        tick();
        check("par_err_pulse", 32'(parity_err), 32'd0);
        beat_data[0] = 8'hC6;
        do_write(12'h0A0, 1'b0, 0, -1, 0);
`endif

        // Randomized traffic with stalls, random ready and spurious mem_rvalid
        noise_en = 1'b1;
        for (int t = 0; t < 14; t++) begin
            op = 1'($urandom);
            br = ($urandom_range(2) == 0);
            ad = AW'($urandom);
            if (op) begin
                if ($urandom_range(1) == 1) ad = last_wr;
                do_read(ad, br, int'($urandom_range(30)), int'($urandom_range(1)), int'($urandom_range(1, 5)));
            end else begin
                for (int b = 0; b < BL; b++) beat_data[b] = DW'($urandom);
                do_write(ad, br, int'($urandom_range(30)), -1, 0);
                last_wr = ad;
            end
        end
        noise_en = 1'b0;

        repeat (4) tick();
        check("total_writes", 32'(n_wr), 32'(exp_wr));
        check("total_reads", 32'(n_rd), 32'(exp_rd));
        check("rx_done_tracks_write", 32'(n_rxd_bad), 32'd0);
        check("total_parity_errs", 32'(n_perr), 32'(exp_perr));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/slave_port_param.md
SLAVE_PORT_PARAM -- requirements
Module: slave_port_param

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, address bits shifted in per command.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data bits per beat.
REQ-003 SHALL have parameter BURST_LEN, default 4, beats per burst command (>=2).
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: read_en, write_en, rx_burst  in  1 each  command type / burst select, sampled at command accept.
REQ-006 SHALL have ports: master_valid  in  1  serial rx bit valid; master_ready  in  1  master accepts tx bit.
REQ-007 SHALL have ports: rx_address, rx_data  in  1 each  serial address / write data, LSB first.
REQ-008 SHALL have ports: slave_ready  out  1  port accepts rx bits; slave_valid  out  1  tx_data valid; tx_data  out  1  serial read data, LSB first.
REQ-009 SHALL have ports: rx_done  out  1  write beat committed; slave_tx_done  out  1  read beat fully sent.
REQ-010 SHALL have ports: mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH; mem_write, mem_read  out  1 each  single-cycle strobes.
REQ-011 SHALL have ports: mem_rdata  in  DATA_WIDTH; mem_rvalid  in  1  read data valid, arbitrary latency.
REQ-012 SHALL have port parity_err  out  1  write parity failure pulse.

Function
REQ-013 SHALL implement states IDLE, ADDR, WDATA, MWRITE, MREAD, MWAIT, TX.
REQ-014 IDLE: command accepted when master_valid=1 and exactly one of read_en/write_en=1; op and rx_burst latched; rx_address that cycle is address bit 0; next ADDR. Both enables high or neither: ignored, stay IDLE.
REQ-015 ADDR: one rx_address bit shifted per cycle with master_valid=1; master_valid=0 stalls, no bit taken; after bit ADDR_WIDTH-1 -> WDATA (write) or MREAD (read).
REQ-016 WDATA: DATA_WIDTH rx_data bits shifted, master_valid gating as in ADDR; then MWRITE.
REQ-017 MWRITE: mem_write=1 and rx_done=1 for exactly one cycle with mem_addr/mem_wdata stable.
REQ-018 MREAD: mem_read=1 one cycle; MWAIT until mem_rvalid=1, mem_rdata captured that cycle; next TX.
REQ-019 TX: slave_valid=1, tx_data = current bit; bit index advances only on cycles with master_ready=1; after DATA_WIDTH accepted bits, slave_tx_done=1 one cycle.
REQ-020 Burst: after each beat, if fewer than BURST_LEN beats done, address += 1 modulo 2^ADDR_WIDTH (0xFFF->0x000) and return to WDATA/MREAD; else IDLE. Non-burst: one beat.
REQ-021 slave_ready SHALL be 1 exactly in IDLE, ADDR, WDATA (state decode); all other outputs registered.
REQ-022 mem_rvalid outside MWAIT and master_ready outside TX SHALL be ignored.

Reset
REQ-023 reset low SHALL immediately force IDLE, clear counters/shift registers; outputs 0 except slave_ready=1.
REQ-024 Reset mid-command SHALL abort it with no further mem strobe; next command after release behaves normally.

Configuration
REQ-025 Macro SLAVE_PORT_PARITY_EN defined: WDATA takes DATA_WIDTH+1 bits, last = even parity of the word; mismatch -> no mem_write, no rx_done, parity_err=1 one cycle, burst aborted to IDLE; TX appends even parity bit after data before slave_tx_done.
REQ-026 Macro undefined: no parity bits in either direction; parity_err tied 0.

Verification (ADDR_WIDTH=12, DATA_WIDTH=8, BURST_LEN=4)
REQ-027 Write addr 0x5A3, data 0xC6, master_valid continuous -> one mem_write, mem_addr=0x5A3, mem_wdata=0xC6, rx_done pulse same cycle, 20 bits after accept.
REQ-028 Read addr 0x010, mem_rvalid 3 cycles after mem_read with 0x3C, master_ready toggling 1/0 -> tx_data 0,0,1,1,1,1,0,0 on accepted cycles, slave_tx_done after 8th.
REQ-029 Burst write at 0xFFE, data 0x11,0x22,0x33,0x44 -> writes to 0xFFE,0xFFF,0x000,0x001 in order, then IDLE.
REQ-030 master_valid low 3 cycles mid-address, read_en=write_en=1 in IDLE -> address unaffected by stall; dual-enable ignored, no strobes.
REQ-031 reset low during TX bit 3 -> slave_valid=0 immediately, slave_ready=1; subsequent write of 0x7F to 0x001 succeeds.
REQ-032 SLAVE_PORT_PARITY_EN: write 0xC6 with parity bit 1 -> no mem_write, parity_err pulse; with parity bit 0 -> normal write.
